// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle processor control FSM; MULTICYCLE_CTRL_LINK_EN enables the BL link state
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_w,
    output logic       reg_w,
    output logic       flag_w,
    output logic       alu_src_a,
    output logic       alu_op,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        LINK   = 4'd10
    } state_t;

    state_t r_state, w_next;
    logic   w_unused;

    assign state    = r_state;
    assign w_unused = ^funct[2:1];

    // state register, reset wins over any in-flight access
    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    // next-state and per-state outputs; reset forces every output low
    always_comb begin
        w_next     = FETCH;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        flag_w     = 1'b0;
        alu_src_a  = 1'b0;
        alu_op     = 1'b0;
        illegal    = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        reg_src    = 2'b00;
        case (r_state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                w_next     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                imm_src = op;
                reg_src = {op == 2'b01 && !funct[0], op == 2'b10};
                if (cond_ex) begin
                    case (op)
                        2'b00: w_next = funct[5] ? EXECI : EXECR;
                        2'b01: w_next = MEMADR;
`ifdef MULTICYCLE_CTRL_LINK_EN
                        2'b10: w_next = funct[4] ? LINK : BRANCH;
`else
                        2'b10: w_next = BRANCH;
`endif
                        default: illegal = 1'b1;
                    endcase
                end
            end
            EXECR: begin
                alu_op = 1'b1;
                w_next = ALUWB;
            end
            EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                w_next    = ALUWB;
            end
            ALUWB: begin
                flag_w = funct[0];
                reg_w  = funct[4:3] != 2'b10;
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                w_next    = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                w_next  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWR: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = mem_ready;
                w_next  = mem_ready ? FETCH : MEMWR;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_LINK_EN
            LINK: begin
                reg_w      = 1'b1;
                result_src = 2'b10;
                reg_src    = 2'b01;
                w_next     = BRANCH;
            end
`endif
            default: w_next = FETCH;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_w      = 1'b0;
            reg_w      = 1'b0;
            flag_w     = 1'b0;
            alu_src_a  = 1'b0;
            alu_op     = 1'b0;
            illegal    = 1'b0;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            imm_src    = 2'b00;
            reg_src    = 2'b00;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl (honours MULTICYCLE_CTRL_LINK_EN)
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset, cond_ex, mem_ready;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_req, ir_write, pc_write, adr_src, mem_w, reg_w, flag_w, alu_src_a, alu_op, illegal;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic [3:0] state;
    logic [21:0] obs;

    localparam logic [9:0] NONE = 10'b0000000000;
    localparam logic [9:0] MREQ = 10'b1000000000;
    localparam logic [9:0] IRW  = 10'b0100000000;
    localparam logic [9:0] PCW  = 10'b0010000000;
    localparam logic [9:0] ADR  = 10'b0001000000;
    localparam logic [9:0] MW   = 10'b0000100000;
    localparam logic [9:0] RW   = 10'b0000010000;
    localparam logic [9:0] FW   = 10'b0000001000;
    localparam logic [9:0] AOP  = 10'b0000000010;
    localparam logic [9:0] ILL  = 10'b0000000001;

    typedef struct {
        logic [21:0] ex;
        string       tag;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .cond_ex(cond_ex), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src), .mem_w(mem_w),
        .reg_w(reg_w), .flag_w(flag_w), .alu_src_a(alu_src_a), .alu_op(alu_op), .illegal(illegal),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
        .state(state)
    );

    assign obs = {state, mem_req, ir_write, pc_write, adr_src, mem_w, reg_w, flag_w, alu_src_a,
                  alu_op, illegal, alu_src_b, result_src, imm_src, reg_src};

    always #5 clk = ~clk;

    function automatic logic [21:0] e(input logic [3:0] st, input logic [9:0] s, input logic [1:0] asb,
                                      input logic [1:0] rs, input logic [1:0] is, input logic [1:0] rgs);
        return {st, s, asb, rs, is, rgs};
    endfunction

    task automatic step(input logic rst, input logic [1:0] o, input logic [5:0] f, input logic c,
                        input logic m, input logic [21:0] ex, input string tag);
        item_t it;
        reset = rst; op = o; funct = f; cond_ex = c; mem_ready = m;
        sb.push_back('{ex, tag});
        @(negedge clk);
        it = sb.pop_front();
        checks++;
        assert (obs === it.ex) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", it.tag, obs, it.ex);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 2'b00; funct = 6'd0; cond_ex = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 2'b00, 6'd0, 0, 1, e(0, NONE, 2'b00, 2'b00, 2'b00, 2'b00), "reset");
        step(0, 2'b00, 6'b101000, 1, 0, e(0, MREQ, 2'b10, 2'b10, 2'b00, 2'b00), "fetch_hold");
        step(0, 2'b00, 6'b101000, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "add_fetch");
        step(0, 2'b00, 6'b101000, 1, 0, e(1, NONE, 2'b00, 2'b00, 2'b00, 2'b00), "add_decode");
        step(0, 2'b00, 6'b101000, 1, 1, e(7, AOP, 2'b01, 2'b00, 2'b00, 2'b00), "add_execi");
        step(0, 2'b00, 6'b101000, 1, 0, e(8, RW, 2'b00, 2'b00, 2'b00, 2'b00), "add_aluwb");
        step(0, 2'b01, 6'b011001, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "ldr_fetch");
        step(0, 2'b01, 6'b011001, 1, 1, e(1, NONE, 2'b00, 2'b00, 2'b01, 2'b00), "ldr_decode");
        step(0, 2'b01, 6'b011001, 1, 1, e(2, NONE, 2'b01, 2'b00, 2'b00, 2'b00), "ldr_memadr");
        step(0, 2'b01, 6'b011001, 1, 0, e(3, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "ldr_wait1");
        step(0, 2'b01, 6'b011001, 1, 0, e(3, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "ldr_wait2");
        step(0, 2'b01, 6'b011001, 1, 0, e(3, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "ldr_wait3");
        step(0, 2'b01, 6'b011001, 1, 1, e(3, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "ldr_ready");
        step(0, 2'b01, 6'b011001, 1, 0, e(4, RW, 2'b00, 2'b01, 2'b00, 2'b00), "ldr_memwb");
        step(0, 2'b01, 6'b011000, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "str_fetch");
        step(0, 2'b01, 6'b011000, 1, 0, e(1, NONE, 2'b00, 2'b00, 2'b01, 2'b10), "str_decode");
        step(0, 2'b01, 6'b011000, 1, 0, e(2, NONE, 2'b01, 2'b00, 2'b00, 2'b00), "str_memadr");
        step(0, 2'b01, 6'b011000, 1, 0, e(5, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "str_wait");
        step(0, 2'b01, 6'b011000, 1, 1, e(5, MREQ|ADR|MW, 2'b00, 2'b00, 2'b00, 2'b00), "str_write");
        step(0, 2'b00, 6'b010101, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "cmp_fetch");
        step(0, 2'b00, 6'b010101, 1, 0, e(1, NONE, 2'b00, 2'b00, 2'b00, 2'b00), "cmp_decode");
        step(0, 2'b00, 6'b010101, 1, 0, e(6, AOP, 2'b00, 2'b00, 2'b00, 2'b00), "cmp_execr");
        step(0, 2'b00, 6'b010101, 1, 0, e(8, FW, 2'b00, 2'b00, 2'b00, 2'b00), "cmp_aluwb");
        step(0, 2'b01, 6'b011001, 0, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "null_fetch");
        step(0, 2'b01, 6'b011001, 0, 1, e(1, NONE, 2'b00, 2'b00, 2'b01, 2'b00), "null_decode");
        step(0, 2'b10, 6'b010000, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "bl_fetch");
        step(0, 2'b10, 6'b010000, 1, 0, e(1, NONE, 2'b00, 2'b00, 2'b10, 2'b01), "bl_decode");
`ifdef MULTICYCLE_CTRL_LINK_EN
        step(0, 2'b10, 6'b010000, 1, 0, e(10, RW, 2'b00, 2'b10, 2'b00, 2'b01), "bl_link");
`endif
        step(0, 2'b10, 6'b010000, 1, 0, e(9, PCW, 2'b01, 2'b10, 2'b00, 2'b00), "bl_branch");
        step(0, 2'b11, 6'b000000, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "ill_fetch");
        step(0, 2'b11, 6'b000000, 1, 0, e(1, ILL, 2'b00, 2'b00, 2'b11, 2'b00), "ill_decode");
        step(0, 2'b11, 6'b000000, 1, 0, e(0, MREQ, 2'b10, 2'b10, 2'b00, 2'b00), "ill_after");
        step(0, 2'b01, 6'b011001, 1, 1, e(0, MREQ|IRW|PCW, 2'b10, 2'b10, 2'b00, 2'b00), "rst_fetch");
        step(0, 2'b01, 6'b011001, 1, 0, e(1, NONE, 2'b00, 2'b00, 2'b01, 2'b00), "rst_decode");
        step(0, 2'b01, 6'b011001, 1, 0, e(2, NONE, 2'b01, 2'b00, 2'b00, 2'b00), "rst_memadr");
        step(0, 2'b01, 6'b011001, 1, 0, e(3, MREQ|ADR, 2'b00, 2'b00, 2'b00, 2'b00), "rst_memrd");
        step(1, 2'b01, 6'b011001, 1, 1, e(3, NONE, 2'b00, 2'b00, 2'b00, 2'b00), "rst_forced");
        step(1, 2'b01, 6'b011001, 1, 1, e(0, NONE, 2'b00, 2'b00, 2'b00, 2'b00), "rst_state");
        step(0, 2'b01, 6'b011001, 1, 0, e(0, MREQ, 2'b10, 2'b10, 2'b00, 2'b00), "rst_release");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port op, input, 2, instruction bits [27:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6, instruction bits [25:20] from the instruction register.
REQ-005 SHALL have port cond_ex, input, 1, condition check passed for the current instruction.
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-007 SHALL have port mem_req, output, 1, memory access request.
REQ-008 SHALL have the following outputs, each 1 bit: ir_write, pc_write, adr_src, mem_w, reg_w, flag_w, alu_src_a, alu_op, illegal.
REQ-009 SHALL have the following outputs, each 2 bits: alu_src_b, result_src, imm_src, reg_src.
REQ-010 SHALL have port state, output, 4, current state, for debug.

Function
REQ-011 SHALL use state encoding FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, LINK=10; any other encoding SHALL go to FETCH on the next edge.
REQ-012 FETCH: mem_req=1, adr_src=0, alu_src_b=2'b10, result_src=2'b10; hold until mem_ready=1.
REQ-013 FETCH with mem_ready=1: ir_write=1 and pc_write=1 for that cycle only, then go to DECODE.
REQ-014 DECODE: imm_src=op, reg_src[1]=(op==01 && !funct[0]), reg_src[0]=(op==10).
REQ-015 DECODE with cond_ex=0: go to FETCH and assert no write strobe (instruction nullified).
REQ-016 DECODE with cond_ex=1: op=00 goes to EXECI if funct[5] else EXECR; op=01 goes to MEMADR; op=10 goes to BRANCH (see REQ-026); op=11 asserts illegal=1 for one cycle and goes to FETCH.
REQ-017 EXECR: alu_src_b=00, alu_op=1. EXECI: alu_src_b=01, alu_op=1. Both go to ALUWB.
REQ-018 ALUWB: result_src=00, flag_w=funct[0], reg_w=(funct[4:3]!=2'b10) (compare/test ops do not write a register); go to FETCH.
REQ-019 MEMADR: alu_src_b=01, alu_op=0; go to MEMRD if funct[0], else MEMWR.
REQ-020 MEMRD: mem_req=1, adr_src=1; hold until mem_ready, then go to MEMWB.
REQ-021 MEMWR: mem_req=1, adr_src=1, and mem_w=1 only in the cycle mem_ready=1; then go to FETCH.
REQ-022 MEMWB: result_src=01, reg_w=1; go to FETCH.
REQ-023 BRANCH: alu_src_b=01, result_src=10, pc_write=1; go to FETCH.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 mem_req SHALL remain high, with stable address select, until mem_ready is seen; mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.

Configuration
REQ-026 With macro MULTICYCLE_CTRL_LINK_EN defined: DECODE with op=10 and funct[4]=1 goes to LINK. LINK asserts reg_w=1, result_src=10 and reg_src=01 (write PC+4 to R14), then goes to BRANCH.
REQ-027 Without MULTICYCLE_CTRL_LINK_EN, BL SHALL behave as B, and the LINK state SHALL be unreachable (treated as illegal per REQ-011).

Reset
REQ-028 While reset=1 at a clock edge, state SHALL become FETCH.
REQ-029 While reset=1, all outputs except state SHALL be forced to 0.
REQ-030 Reset SHALL override mem_ready and any in-flight access; the first cycle after release SHALL present FETCH outputs.

Verification
REQ-031 ADD immediate (op=00, funct=6'b101000, cond_ex=1), mem_ready=1 in fetch -> states 0,1,7,8,0; reg_w=1 and flag_w=0 in ALUWB.
REQ-032 LDR (op=01, funct=6'b011001), mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles; reg_w=1 once in MEMWB.
REQ-033 STR (op=01, funct=6'b011000) -> mem_w=1 only in the MEMWR cycle where mem_ready=1; reg_w=0 throughout.
REQ-034 CMP (funct=6'b010101), then any op with cond_ex=0 -> CMP gives flag_w=1 and reg_w=0 in ALUWB; the nullified instruction gives DECODE→FETCH with no strobes.
REQ-035 BL (op=10, funct=6'b010000), both macro builds -> with macro: states 1,10,9 with reg_w=1 in LINK; without macro: states 1,9 and no reg_w.
REQ-036 op=11 gives illegal=1 for one cycle; reset asserted mid-MEMRD gives state=0, all strobes 0, and FETCH outputs on the next cycle after release.
